exe_div: RTL and testbench



---
 rtl/exe_div_pkg.sv | 7 +
 rtl/exe_div_if.sv | 18 +
 rtl/exe_div_iter.sv | 13 +
 rtl/exe_div.sv | 100 ++++++++++
 tb/tb_exe_div.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/exe_div_pkg.sv
// exe_div_pkg: shared types and constants for the iterative divide unit.
package exe_div_pkg;
    typedef enum logic [1:0] {DIV_S, DIV_U, REM_S, REM_U} DivOp_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} DivState_t;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
endpackage

// File: rtl/exe_div_if.sv
// exe_div_if: issue, flush and writeback signals of the divide unit.
interface exe_div_if import exe_div_pkg::*; #(parameter int DATA = 32, parameter int ROB = 5) ();
    logic            issue_div_;
    DivOp_t          issue_op;
    logic [ROB-1:0]  issue_rob;
    logic [DATA-1:0] issue_src1;
    logic [DATA-1:0] issue_src2;
    logic            flush_;
    logic            div_busy;
    logic            wb_e_;
    logic [ROB-1:0]  wb_rob;
    logic [DATA-1:0] wb_data;
    logic            wb_grant_;
    modport master (output issue_div_, issue_op, issue_rob, issue_src1, issue_src2, flush_, wb_grant_,
                    input div_busy, wb_e_, wb_rob, wb_data);
    modport slave (input issue_div_, issue_op, issue_rob, issue_src1, issue_src2, flush_, wb_grant_,
                   output div_busy, wb_e_, wb_rob, wb_data);
endinterface

// File: rtl/exe_div_iter.sv
// div_iter: one combinational radix-2 restoring divide step.
module div_iter #(parameter int DATA = 32) (
    input  logic [DATA:0]   rem,
    input  logic [DATA-1:0] quo,
    input  logic [DATA-1:0] dvs,
    output logic [DATA:0]   rem_n,
    output logic [DATA-1:0] quo_n
);
    logic [DATA+1:0] diff;
    assign diff  = {rem, quo[DATA-1]} - {2'b00, dvs};
    assign rem_n = diff[DATA+1] ? {rem[DATA-1:0], quo[DATA-1]} : diff[DATA:0];
    assign quo_n = {quo[DATA-2:0], ~diff[DATA+1]};
endmodule

// File: rtl/exe_div.sv
// exe_div: iterative DIV/DIVU/REM/REMU unit with a held writeback result.
// Optional DIV_REUSE_EN: replay the last completed result for matching operands.
module exe_div import exe_div_pkg::*; #(parameter int DATA = 32, parameter int ROB = 5) (
    input logic clk,
    input logic reset_,
    exe_div_if.slave d
);
    localparam int CW = $clog2(DATA);
    localparam logic [DATA-1:0] MIN = {1'b1, {(DATA-1){1'b0}}};
    DivState_t state;
    logic [DATA:0] rem, rem_n;
    logic [DATA-1:0] quo, quo_n, dvs, a_mag, b_mag, q_fix, r_fix, hit_data;
    logic [CW-1:0] cnt;
    logic is_rem, neg_q, neg_r, sgn, a_neg, b_neg, issue_rem, ovf, hit;
    assign sgn       = d.issue_op inside {DIV_S, REM_S};
    assign issue_rem = d.issue_op inside {REM_S, REM_U};
    assign a_neg     = sgn & d.issue_src1[DATA-1];
    assign b_neg     = sgn & d.issue_src2[DATA-1];
    assign a_mag     = a_neg ? -d.issue_src1 : d.issue_src1;
    assign b_mag     = b_neg ? -d.issue_src2 : d.issue_src2;
    assign ovf       = sgn && d.issue_src1 == MIN && &d.issue_src2;
    assign q_fix     = neg_q ? -quo : quo;
    assign r_fix     = neg_r ? -rem[DATA-1:0] : rem[DATA-1:0];
    div_iter #(.DATA(DATA)) u_iter (.rem(rem), .quo(quo), .dvs(dvs), .rem_n(rem_n), .quo_n(quo_n));
`ifdef DIV_REUSE_EN
    logic last_v, last_sgn, pend_sgn;
    logic [DATA-1:0] last_a, last_b, last_q, last_r, pend_a, pend_b;
    assign hit      = last_v && last_sgn == sgn && last_a == d.issue_src1 && last_b == d.issue_src2;
    assign hit_data = issue_rem ? last_r : last_q;
    // Valid survives flushes; only reset forgets the stored result.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            {last_v, last_sgn, pend_sgn} <= '0;
            {last_a, last_b, last_q, last_r, pend_a, pend_b} <= '0;
        end else if (d.flush_) begin
            if (state == IDLE && !d.issue_div_) {pend_sgn, pend_a, pend_b} <= {sgn, d.issue_src1, d.issue_src2};
            if (state == FIX) begin
                {last_v, last_sgn, last_a, last_b} <= {1'b1, pend_sgn, pend_a, pend_b};
                {last_q, last_r} <= {q_fix, r_fix};
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            d.div_busy <= 1'b0;
            d.wb_e_    <= Disable_;
            d.wb_rob   <= ROB'(0);
            d.wb_data  <= '0;
            {rem, quo, dvs, cnt, is_rem, neg_q, neg_r} <= '0;
        end else if (!d.flush_) begin
            state      <= IDLE;
            d.div_busy <= 1'b0;
            d.wb_e_    <= Disable_;
        end else begin
            case (state)
                IDLE: if (!d.issue_div_) begin
                    d.div_busy <= 1'b1;
                    d.wb_rob   <= d.issue_rob;
                    is_rem     <= issue_rem;
                    neg_q      <= a_neg ^ b_neg;
                    neg_r      <= a_neg;
                    quo        <= a_mag;
                    dvs        <= b_mag;
                    rem        <= '0;
                    cnt        <= CW'(DATA - 1);
                    if (d.issue_src2 == '0 || ovf || hit) begin
                        d.wb_data <= d.issue_src2 == '0 ? (issue_rem ? d.issue_src1 : '1) :
                                     ovf ? (issue_rem ? '0 : MIN) : hit_data;
                        d.wb_e_   <= Enable_;
                        state     <= DONE;
                    end else state <= CALC;
                end
                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    d.wb_data <= is_rem ? r_fix : q_fix;
                    d.wb_e_   <= Enable_;
                    state     <= DONE;
                end
                DONE: if (!d.wb_grant_) begin
                    d.wb_e_    <= Disable_;
                    d.div_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Issue must respect busy; a strobe while busy is silently dropped.
    assert property (@(posedge clk) disable iff (!reset_) !(d.div_busy && !d.issue_div_));
endmodule

// File: tb/tb_exe_div.sv
// tb_exe_div: table-driven directed bench for exe_div plus flush/hold/reset sequences.
module tb_exe_div;
    import exe_div_pkg::*;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int pass = 0;
    int total = 0;
    exe_div_if #(.DATA(32), .ROB(5)) bus ();
    exe_div #(.DATA(32), .ROB(5)) dut (.clk(clk), .reset_(reset_), .d(bus));
    always #5 clk = ~clk;
`ifdef DIV_REUSE_EN
    localparam int RL = 1;
`else
    localparam int RL = 34;
`endif
    typedef struct {
        DivOp_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t v[14];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask
    task automatic issue(input DivOp_t op, input logic [4:0] rob, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.issue_op = op; bus.issue_rob = rob; bus.issue_src1 = a; bus.issue_src2 = b;
        bus.issue_div_ = 1'b0;
        @(posedge clk); #1;
        bus.issue_div_ = 1'b1;
    endtask
    task automatic wait_wb(output int lat);
        lat = 1;
        while (bus.wb_e_ && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
    task automatic run_op(input string name, input DivOp_t op, input logic [4:0] rob, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        issue(op, rob, a, b);
        chk({name, " busy_after_issue"}, 32'(bus.div_busy), 32'd1);
        wait_wb(lat);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " data"}, bus.wb_data, exp);
        chk({name, " rob"}, 32'(bus.wb_rob), 32'(rob));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({name, " hold_data"}, bus.wb_data, exp);
            chk({name, " hold_busy"}, 32'(bus.div_busy), 32'd1);
            chk({name, " hold_wb_e"}, 32'(bus.wb_e_), 32'd0);
        end
        bus.wb_grant_ = 1'b0;
        @(posedge clk); #1;
        bus.wb_grant_ = 1'b1;
        chk({name, " wb_e_after_grant"}, 32'(bus.wb_e_), 32'd1);
        chk({name, " busy_after_grant"}, 32'(bus.div_busy), 32'd0);
    endtask
    initial begin
        int lat;
        logic seen;
        bus.issue_div_ = 1'b1; bus.flush_ = 1'b1; bus.wb_grant_ = 1'b1;
        bus.issue_op = DIV_U; bus.issue_rob = '0; bus.issue_src1 = '0; bus.issue_src2 = '0;
        v[0]  = '{DIV_S, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 34};
        v[1]  = '{REM_U, 32'hFFFFFFFF,   32'd0,        32'hFFFFFFFF, 1};
        v[2]  = '{DIV_U, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        v[3]  = '{DIV_S, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        v[4]  = '{REM_S, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        v[5]  = '{DIV_U, 32'd1000,       32'd3,        32'd333,      34};
        v[6]  = '{REM_U, 32'd1000,       32'd3,        32'd1,        RL};
        v[7]  = '{DIV_S, 32'hFFFFFF9C,   32'd9,        32'hFFFFFFF5, 34};
        v[8]  = '{REM_S, 32'd100,        32'hFFFFFFF9, 32'd2,        34};
        v[9]  = '{DIV_U, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 34};
        v[10] = '{REM_U, 32'd7,          32'd10,       32'd7,        34};
        v[11] = '{DIV_S, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        v[12] = '{REM_S, 32'hFFFFFFFF,   32'd0,        32'hFFFFFFFF, 1};
        v[13] = '{DIV_S, 32'h80000000,   32'd1,        32'h80000000, 34};
        #12;
        chk("reset busy", 32'(bus.div_busy), 32'd0);
        chk("reset wb_e", 32'(bus.wb_e_), 32'd1);
        chk("reset rob", 32'(bus.wb_rob), 32'd0);
        chk("reset data", bus.wb_data, 32'd0);
        @(negedge clk) reset_ = 1'b1;
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), v[i].op, 5'(i + 3), v[i].a, v[i].b, v[i].exp, v[i].lat, 0);
        run_op("hold_rem_s", REM_S, 5'd21, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 10);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= ~bus.wb_e_;
        end
        chk("hold single_writeback", 32'(seen), 32'd0);
        issue(DIV_U, 5'd9, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 bus.flush_ = 1'b0;
        @(posedge clk); #1;
        bus.flush_ = 1'b1;
        chk("flush wb_e", 32'(bus.wb_e_), 32'd1);
        chk("flush busy", 32'(bus.div_busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= ~bus.wb_e_;
        end
        chk("flush no_writeback", 32'(seen), 32'd0);
        run_op("after_flush", DIV_U, 5'd10, 32'd1000, 32'd7, 32'd142, 34, 0);
        @(posedge clk); #1;
        bus.issue_op = DIV_U; bus.issue_src1 = 32'd9; bus.issue_src2 = 32'd0;
        bus.issue_div_ = 1'b0; bus.flush_ = 1'b0;
        @(posedge clk); #1;
        bus.issue_div_ = 1'b1; bus.flush_ = 1'b1;
        chk("flush_issue busy", 32'(bus.div_busy), 32'd0);
        chk("flush_issue wb_e", 32'(bus.wb_e_), 32'd1);
        issue(DIV_U, 5'd11, 32'd50, 32'd5);
        wait_wb(lat);
        chk("flush_grant latency", lat, 34);
        chk("flush_grant data", bus.wb_data, 32'd10);
        bus.flush_ = 1'b0; bus.wb_grant_ = 1'b0;
        @(posedge clk); #1;
        bus.flush_ = 1'b1; bus.wb_grant_ = 1'b1;
        seen = bus.div_busy;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= ~bus.wb_e_;
        end
        chk("flush_grant idle_once", 32'(seen), 32'd0);
        issue(DIV_U, 5'd12, 32'd77, 32'd3);
        repeat (5) @(posedge clk);
        #2 reset_ = 1'b0;
        #1;
        chk("async_reset busy", 32'(bus.div_busy), 32'd0);
        chk("async_reset wb_e", 32'(bus.wb_e_), 32'd1);
        chk("async_reset rob", 32'(bus.wb_rob), 32'd0);
        chk("async_reset data", bus.wb_data, 32'd0);
        @(negedge clk) reset_ = 1'b1;
        run_op("after_reset", REM_U, 5'd13, 32'd77, 32'd3, 32'd2, 34, 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
